// File: rtl/mem64_arbiter.sv
`timescale 1ns / 1ps
// mem64_arbiter
// Two-requester arbiter and access sequencer for the single-port 64-bit data
// memory of the multicycle RISC-V core. The CPU load/store path and the
// debug/loader port share the memory. Accesses are serialised through
// IDLE -> ACCESS -> DONE. All requester-side and memory-side outputs are registered.
//
// Parameters:
//   RD_LAT    number of ACCESS cycles for a read (1..7). Read data is
//             sampled in the last ACCESS cycle.
// Ports:
//   Clk, Reset                     clock; asynchronous active-high reset
//   cpu_req/we/addr/wdata          CPU request. req is sampled only in IDLE.
//   cpu_gnt, cpu_done              one-cycle accept / complete pulses
//   cpu_rdata                      last CPU read data, held until the next CPU read
//   dbg_*                          same set of ports for the debug/loader port
//   mem_addr, mem_wdata, mem_wr    memory address, write data, write enable
//   mem_rdata                      memory read data
//   busy                           high whenever the state is not IDLE
// Configuration:
//   MEM64_ARB_RR_EN  defined: round-robin on ties. Undefined: the CPU always wins ties.
module mem64_arbiter #(
   parameter int unsigned RD_LAT = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [63:0] cpu_addr,
   input  logic [63:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_done,
   output logic [63:0] cpu_rdata,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [63:0] dbg_addr,
   input  logic [63:0] dbg_wdata,
   output logic        dbg_gnt,
   output logic        dbg_done,
   output logic [63:0] dbg_rdata,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic        mem_wr,
   input  logic [63:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} arbState;

   localparam logic [2:0] LastCnt = 3'(RD_LAT - 1);

   arbState    state;
   logic [2:0] accCnt;
   logic       isWrite;
   logic       winnerDbg;
   logic       pickDbg;

`ifdef MEM64_ARB_RR_EN
   // Tracks the last grant. Reset value is dbg, so the CPU wins the first tie.
   logic lastDbg;

   assign pickDbg = dbg_req & (~cpu_req | ~lastDbg);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         lastDbg <= 1'b1;
      end else if (state == StIdle && (cpu_req || dbg_req)) begin
         lastDbg <= pickDbg;
      end
   end
`else
   assign pickDbg = dbg_req & ~cpu_req;
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= StIdle;
         accCnt    <= 3'd0;
         isWrite   <= 1'b0;
         winnerDbg <= 1'b0;
         cpu_gnt   <= 1'b0;
         cpu_done  <= 1'b0;
         cpu_rdata <= 64'd0;
         dbg_gnt   <= 1'b0;
         dbg_done  <= 1'b0;
         dbg_rdata <= 64'd0;
         mem_addr  <= 64'd0;
         mem_wdata <= 64'd0;
         mem_wr    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         // Pulse outputs default low. Each state raises only what it owns.
         cpu_gnt  <= 1'b0;
         dbg_gnt  <= 1'b0;
         cpu_done <= 1'b0;
         dbg_done <= 1'b0;
         mem_wr   <= 1'b0;
         unique case (state)
            StIdle: begin
               if (cpu_req || dbg_req) begin
                  winnerDbg <= pickDbg;
                  isWrite   <= pickDbg ? dbg_we : cpu_we;
                  mem_addr  <= pickDbg ? dbg_addr : cpu_addr;
                  mem_wdata <= pickDbg ? dbg_wdata : cpu_wdata;
                  // Write enable is valid only in the first (and only) write ACCESS cycle.
                  mem_wr    <= pickDbg ? dbg_we : cpu_we;
                  cpu_gnt   <= ~pickDbg;
                  dbg_gnt   <= pickDbg;
                  accCnt    <= 3'd0;
                  busy      <= 1'b1;
                  state     <= StAccess;
               end
            end
            StAccess: begin
               if (isWrite) begin
                  cpu_done <= ~winnerDbg;
                  dbg_done <= winnerDbg;
                  state    <= StDone;
               end else if (accCnt == LastCnt) begin
                  if (winnerDbg) begin
                     dbg_rdata <= mem_rdata;
                  end else begin
                     cpu_rdata <= mem_rdata;
                  end
                  cpu_done <= ~winnerDbg;
                  dbg_done <= winnerDbg;
                  state    <= StDone;
               end else begin
                  accCnt <= accCnt + 3'd1;
               end
            end
            StDone: begin
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: begin
               busy  <= 1'b0;
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem64_arbiter.sv
`timescale 1ns / 1ps
module tb_mem64_arbiter;

   logic        Clk;
   logic        Reset;
   logic        cpu_req, cpu_we, cpu_gnt, cpu_done;
   logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        dbg_req, dbg_we, dbg_gnt, dbg_done;
   logic [63:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_wr, busy;

   int checks = 0;
   int errors = 0;

   // Small memory model: 16 doublewords, combinational read, cleared on reset.
   logic [63:0] memArr [16];
   assign mem_rdata = memArr[mem_addr[6:3]];

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < 16; i++) memArr[i] <= 64'd0;
      end else if (mem_wr) begin
         memArr[mem_addr[6:3]] <= mem_wdata;
      end
   end

   mem64_arbiter #(.RD_LAT(2)) uDut (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   // Extra instances for the read-latency sweep (RD_LAT = 1, 4, 7).
   logic        latReq;
   logic [63:0] latMemRdata;
   logic        latGnt [3];
   logic        latDone [3];
   logic [63:0] latRdata [3];
   logic        latDbgGnt [3];
   logic        latDbgDone [3];
   logic [63:0] latDbgRdata [3];
   logic [63:0] latMemAddr [3];
   logic [63:0] latMemWdata [3];
   logic        latMemWr [3];
   logic        latBusy [3];

   function automatic int latOf(input int g);
      return (g == 0) ? 1 : ((g == 1) ? 4 : 7);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gLat
      mem64_arbiter #(.RD_LAT((g == 0) ? 1 : ((g == 1) ? 4 : 7))) uLat (
         .Clk(Clk), .Reset(Reset),
         .cpu_req(latReq), .cpu_we(1'b0), .cpu_addr(64'h20), .cpu_wdata(64'd0),
         .cpu_gnt(latGnt[g]), .cpu_done(latDone[g]), .cpu_rdata(latRdata[g]),
         .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(64'd0), .dbg_wdata(64'd0),
         .dbg_gnt(latDbgGnt[g]), .dbg_done(latDbgDone[g]), .dbg_rdata(latDbgRdata[g]),
         .mem_addr(latMemAddr[g]), .mem_wdata(latMemWdata[g]), .mem_wr(latMemWr[g]),
         .mem_rdata(latMemRdata), .busy(latBusy[g])
      );
   end

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic tick();
      @(negedge Clk);
   endtask

   task automatic waitIdle();
      int n = 0;
      while (busy !== 1'b0 && n < 20) begin
         tick();
         n++;
      end
      if (busy !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: busy=%b required 0 within 20 cycles", busy);
      end
      tick();
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
      latReq = 0; latMemRdata = 64'h0000_A5A5_0000_5A5A;
      tick(); tick();
      checks++;
      if ({cpu_gnt, dbg_gnt, cpu_done, dbg_done} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_pulses: got %b required 0000", {cpu_gnt, dbg_gnt, cpu_done, dbg_done});
      end
      checks++;
      if ({mem_wr, busy} !== 2'b00) begin
         errors++;
         $display("FAIL reset_wr_busy: got %b required 00", {mem_wr, busy});
      end
      checks++;
      if (cpu_rdata !== 64'd0 || dbg_rdata !== 64'd0) begin
         errors++;
         $display("FAIL reset_rdata: got %h/%h required 0/0", cpu_rdata, dbg_rdata);
      end
      checks++;
      if (mem_addr !== 64'd0 || mem_wdata !== 64'd0) begin
         errors++;
         $display("FAIL reset_mem: got %h/%h required 0/0", mem_addr, mem_wdata);
      end
      Reset = 1'b0;
      tick();
   endtask

   task automatic test_arbitration();
      int nGnt = 0;
      logic [3:0] order = 4'b0000;
      logic [3:0] expOrder;
      logic sawDbg = 1'b0;
`ifdef MEM64_ARB_RR_EN
      expOrder = 4'b1010;
`else
      expOrder = 4'b0000;
`endif
      cpu_req = 1; cpu_we = 0; cpu_addr = 64'h08;
      dbg_req = 1; dbg_we = 0; dbg_addr = 64'h10;
      for (int c = 0; c < 60 && nGnt < 4; c++) begin
         tick();
         if (cpu_gnt === 1'b1 && dbg_gnt === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL arb_dual_gnt: got both grants required one");
         end
         if (cpu_gnt === 1'b1) nGnt++;
         else if (dbg_gnt === 1'b1) begin
            order[nGnt] = 1'b1;
            nGnt++;
         end
      end
      checks++;
      if (nGnt != 4) begin
         errors++;
         $display("FAIL arb_grant_count: got %0d grants required 4", nGnt);
      end
      checks++;
      if (order !== expOrder) begin
         errors++;
         $display("FAIL arb_order: got %b required %b (bit i = 1 means dbg)", order, expOrder);
      end
      cpu_req = 0;
      for (int c = 0; c < 20 && !sawDbg; c++) begin
         tick();
         if (dbg_gnt === 1'b1) sawDbg = 1'b1;
      end
      dbg_req = 0;
      checks++;
      if (sawDbg !== 1'b1) begin
         errors++;
         $display("FAIL arb_dbg_after_cpu_drop: got no dbg_gnt required one");
      end
      waitIdle();
   endtask

   task automatic test_write_read();
      // Write 0x40: cycle 0 is this IDLE cycle.
      cpu_req = 1; cpu_we = 1; cpu_addr = 64'h40; cpu_wdata = 64'hDEADBEEF_CAFEF00D;
      tick();
      checks++;
      if ({cpu_gnt, mem_wr, busy} !== 3'b111 || mem_addr !== 64'h40) begin
         errors++;
         $display("FAIL wr_cycle1: got gnt/wr/busy=%b addr=%h required 111 addr=40",
                  {cpu_gnt, mem_wr, busy}, mem_addr);
      end
      checks++;
      if (mem_wdata !== 64'hDEADBEEF_CAFEF00D) begin
         errors++;
         $display("FAIL wr_wdata: got %h required deadbeefcafef00d", mem_wdata);
      end
      cpu_req = 0;
      tick();
      checks++;
      if ({cpu_done, cpu_gnt, mem_wr} !== 3'b100) begin
         errors++;
         $display("FAIL wr_cycle2: got done/gnt/wr=%b required 100", {cpu_done, cpu_gnt, mem_wr});
      end
      tick();
      checks++;
      if ({busy, cpu_done} !== 2'b00 || mem_addr !== 64'h40) begin
         errors++;
         $display("FAIL wr_cycle3: got busy/done=%b addr=%h required 00 addr=40",
                  {busy, cpu_done}, mem_addr);
      end
      // Read back 0x40.
      cpu_req = 1; cpu_we = 0; cpu_wdata = 64'd0;
      tick();
      checks++;
      if ({cpu_gnt, mem_wr} !== 2'b10) begin
         errors++;
         $display("FAIL rd_cycle1: got gnt/wr=%b required 10", {cpu_gnt, mem_wr});
      end
      cpu_req = 0;
      tick();
      checks++;
      if ({cpu_done, busy} !== 2'b01) begin
         errors++;
         $display("FAIL rd_cycle2: got done/busy=%b required 01", {cpu_done, busy});
      end
      tick();
      checks++;
      if (cpu_done !== 1'b1 || cpu_rdata !== 64'hDEADBEEF_CAFEF00D) begin
         errors++;
         $display("FAIL rd_cycle3: got done=%b rdata=%h required 1 deadbeefcafef00d",
                  cpu_done, cpu_rdata);
      end
      tick();
   endtask

   task automatic runXfer(input logic isDbg, input logic we, input logic [63:0] addr,
                          input logic [63:0] wdata);
      if (isDbg) begin
         dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
      end else begin
         cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      end
      tick();
      cpu_req = 0;
      dbg_req = 0;
      waitIdle();
   endtask

   task automatic test_dbg_rdata();
      runXfer(1'b0, 1'b1, 64'h08, 64'h1234);
      runXfer(1'b0, 1'b1, 64'h10, 64'h5678);
      runXfer(1'b1, 1'b0, 64'h08, 64'h0);
      checks++;
      if (dbg_rdata !== 64'h1234) begin
         errors++;
         $display("FAIL dbg_rd: got %h required 1234", dbg_rdata);
      end
      runXfer(1'b0, 1'b0, 64'h10, 64'h0);
      checks++;
      if (cpu_rdata !== 64'h5678) begin
         errors++;
         $display("FAIL cpu_rd_after_dbg: got %h required 5678", cpu_rdata);
      end
      checks++;
      if (dbg_rdata !== 64'h1234) begin
         errors++;
         $display("FAIL dbg_rd_held: got %h required 1234", dbg_rdata);
      end
   endtask

   task automatic test_back_to_back();
      int firstGnt = -1;
      int firstDone = -1;
      int secondGnt = -1;
      cpu_req = 1; cpu_we = 1; cpu_addr = 64'h18; cpu_wdata = 64'h1;
      for (int c = 1; c <= 20 && secondGnt < 0; c++) begin
         tick();
         if (cpu_gnt === 1'b1) begin
            if (firstGnt < 0) firstGnt = c;
            else secondGnt = c;
         end
         if (cpu_done === 1'b1 && firstDone < 0) firstDone = c;
      end
      cpu_req = 0;
      checks++;
      if (firstGnt != 1 || firstDone != 2) begin
         errors++;
         $display("FAIL b2b_first: got gnt@%0d done@%0d required 1 and 2", firstGnt, firstDone);
      end
      checks++;
      if (secondGnt != 4) begin
         errors++;
         $display("FAIL b2b_second_gnt: got cycle %0d required 4", secondGnt);
      end
      waitIdle();
   endtask

   task automatic test_reset_mid();
      dbg_req = 1; dbg_we = 1; dbg_addr = 64'h28; dbg_wdata = 64'h77;
      tick();
      checks++;
      if ({dbg_gnt, mem_wr, busy} !== 3'b111) begin
         errors++;
         $display("FAIL rstmid_pre: got gnt/wr/busy=%b required 111", {dbg_gnt, mem_wr, busy});
      end
      #2 Reset = 1'b1;
      #1;
      checks++;
      if ({mem_wr, busy} !== 2'b00) begin
         errors++;
         $display("FAIL rstmid_async: got wr/busy=%b required 00", {mem_wr, busy});
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({dbg_done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_no_done: got done/busy=%b required 00", {dbg_done, busy});
         end
      end
      Reset = 1'b0;
      dbg_req = 0; dbg_we = 0;
      tick();
      cpu_req = 1; cpu_we = 0; cpu_addr = 64'h40;
      tick();
      checks++;
      if (cpu_gnt !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_rd_gnt: got %b required 1", cpu_gnt);
      end
      cpu_req = 0;
      tick();
      tick();
      checks++;
      if (cpu_done !== 1'b1 || dbg_done !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_rd_done: got cpu/dbg done=%b%b required 10", cpu_done, dbg_done);
      end
      tick();
   endtask

   task automatic test_rd_lat();
      int doneCyc [3];
      int busyCnt [3];
      for (int g = 0; g < 3; g++) begin
         doneCyc[g] = -1;
         busyCnt[g] = 0;
      end
      latReq = 1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 1) latReq = 0;
         for (int g = 0; g < 3; g++) begin
            if (latBusy[g] === 1'b1) busyCnt[g]++;
            if (latDone[g] === 1'b1 && doneCyc[g] < 0) doneCyc[g] = c;
         end
      end
      for (int g = 0; g < 3; g++) begin
         checks++;
         if (doneCyc[g] != latOf(g) + 1 || busyCnt[g] != latOf(g) + 1) begin
            errors++;
            $display("FAIL rdlat_%0d: got done@%0d busy=%0d required %0d and %0d",
                     latOf(g), doneCyc[g], busyCnt[g], latOf(g) + 1, latOf(g) + 1);
         end
         checks++;
         if (latRdata[g] !== 64'h0000_A5A5_0000_5A5A) begin
            errors++;
            $display("FAIL rdlat_%0d_data: got %h required 0000a5a500005a5a", latOf(g),
                     latRdata[g]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_arbitration();
      test_write_read();
      test_dbg_rdata();
      test_back_to_back();
      test_reset_mid();
      test_rd_lat();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
